mux_arb_nbit: RTL and testbench
===============================

Name: mux_arb_nbit

Overview:
- Parametrised N-input, WIDTH-bit registered multiplexer with a valid/ready handshake on every input and on the output.
- Next generation of the 2-input combinational word muxes.
- Selection is either round-robin arbitration among requesting inputs or a forced channel from a select port, the way the plain muxes are driven.
- Sits between multiple word producers (ALU result, memory read, I/O) and a single consumer; registers the chosen word for one cycle of latency.

Parameters:
- WIDTH, 16, data width per channel in bits (1..64).
- NUM_IN, 4, number of input channels (2..16).
- SEL_W, $clog2(NUM_IN), select/grant index width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-high.
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  channel i has a word.
- in_ready  output  NUM_IN  channel i word accepted this cycle when in_valid[i] && in_ready[i].
- select_en  input  1  1 = forced mode, 0 = round-robin mode.
- select  input  SEL_W  forced channel index when select_en=1.
- out  output  WIDTH  registered selected word.
- out_valid  output  1  out holds a word.
- out_ready  input  1  consumer accepts out when out_valid && out_ready.
- out_select  output  SEL_W  index of the channel that produced out.

Behaviour:
- Reset, synchronous: out=0, out_valid=0, out_select=0, round-robin pointer ptr=0. in_ready=0 during the reset cycle.
- A reset asserted mid-operation discards any held word in that cycle; no transfer completes while reset=1.
- load = !out_valid || out_ready (output register empty or draining this cycle).
- Round-robin mode (select_en=0):
  - grant = first i with in_valid[i]=1, searching ptr, ptr+1, ..., NUM_IN-1, 0, ..., ptr-1 (modulo NUM_IN).
  - No valid input: no grant.
- Forced mode (select_en=1):
  - grant = select if in_valid[select]=1, else no grant.
  - select >= NUM_IN: no grant and no in_ready. Not an error; out_valid simply falls after the drain.
- in_ready[i] = (grant==i) && load && !reset. At most one bit is set; in_ready is combinational from in_valid, select_en, select, out_valid, out_ready and ptr.
- Accept (grant exists and load):
  - Next edge: out <= word of channel grant, out_select <= grant, out_valid <= 1.
  - Latency input-to-out is exactly 1 cycle.
  - Round-robin mode only: ptr <= (grant+1) mod NUM_IN, wrapping NUM_IN-1 -> 0. Forced mode leaves ptr unchanged.
- Drain without accept (out_valid && out_ready, no grant): out_valid <= 0; out and out_select hold their last values.
- Stall (out_valid && !out_ready): out, out_select and out_valid hold; all in_ready=0.
- Simultaneous drain and accept: back-to-back transfer, out_valid stays 1. Full throughput is one word per cycle.
- Mode switch between cycles is allowed; it takes effect on the grant computed in the same cycle.

Optional Feature:
- Macro: MUX_ARB_NBIT_LAST_LOCK_EN.
- With the macro defined:
  - Adds input port in_last (NUM_IN bits).
  - Adds a lock flag (reset 0) and lock_ch (SEL_W bits, reset 0).
  - An accept with in_last[grant]=0 sets lock=1 and lock_ch=grant.
  - While lock=1, grant is lock_ch if in_valid[lock_ch], else no grant. select_en and the round-robin search are ignored.
  - An accept with in_last[lock_ch]=1 clears lock.
  - ptr advances only on a last-word accept.
  - Reset clears lock.
- Without the macro: no in_last port and no lock state; arbitration is per-word as above.

Test Plan:
- Reset held 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out=0. First grant after reset release goes to channel 0.
- Round-robin with all in_valid=1111, data i = 16'h00A0+i, out_ready=1 -> out sequence A0, A1, A2, A3, A0 on consecutive cycles. out_select follows 0, 1, 2, 3, 0 (pointer wrap).
- Forced mode, select_en=1, select=2, in_valid=0110, data2=16'hBEEF -> in_ready=0100, next cycle out=BEEF, out_select=2. With select=0 and in_valid[0]=0 -> no grant, out_valid drops after the drain.
- Backpressure: out_valid=1 holding 16'h1234, out_ready=0 for 3 cycles with inputs valid -> out stays 1234, in_ready=0000. When out_ready=1, the new word loads in the same cycle with no bubble.
- Reset mid-stream: assert reset while out_valid=1 and in_valid=1111 -> next cycle out_valid=0, ptr=0, no in_ready pulse during reset.
- With MUX_ARB_NBIT_LAST_LOCK_EN: channel 1 sends 3 words with in_last=0, 0, 1 while channel 0 is always valid -> out_select is 1, 1, 1, then 0. Channel 0 is not granted until channel 1's last word is accepted.

Source files
------------

// File: rtl/mux_arb_nbit.sv
// mux_arb_nbit: N-input, WIDTH-bit registered word multiplexer with a
// valid/ready handshake on each input channel and on the output.
//
// Handshake: a word moves on any port in a cycle where its valid and ready
// are both high at the rising edge; valid is never withdrawn by this block
// while the output word waits, and ready never depends on the data bits.
//
// Channel choice is either round-robin among requesting inputs (select_en=0)
// or a forced channel index (select_en=1). The chosen word appears on 'out'
// one cycle after acceptance. The output register refills in the same cycle
// it drains, so throughput is one word per cycle.
//
// Optional feature: define MUX_ARB_NBIT_LAST_LOCK_EN to add the in_last port.
// A granted channel then keeps the grant until it delivers a word flagged
// with in_last, so multi-word packets are never interleaved.

module mux_arb_nbit #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
`ifdef MUX_ARB_NBIT_LAST_LOCK_EN
    input  logic [NUM_IN-1:0]       in_last,
`endif
    input  logic                    select_en,
    input  logic [SEL_W-1:0]        select,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_select
);

    // Round-robin search start: the channel just after the last RR winner.
    logic [SEL_W-1:0] ptr;

    // Combinational arbitration result for the current cycle.
    logic [SEL_W-1:0] grant;
    logic             grant_vld;
    logic             load;
    logic             accept;
    logic [WIDTH-1:0] grant_word;
    logic             ptr_adv;
    logic [SEL_W-1:0] ptr_next;

`ifdef MUX_ARB_NBIT_LAST_LOCK_EN
    // Packet lock: holds the grant on lock_ch until its last word is taken.
    // lock_rr remembers whether the packet started in round-robin mode, so
    // the pointer only advances for packets that were arbitrated.
    logic             lock;
    logic [SEL_W-1:0] lock_ch;
    logic             lock_rr;
`endif

    // The output register can take a word when it is empty or draining now.
    assign load   = !out_valid || out_ready;
    assign accept = grant_vld && load && !reset;

    // Grant selection: lock (if built in), then forced index, then RR search.
    always_comb begin
        int idx;
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
`ifdef MUX_ARB_NBIT_LAST_LOCK_EN
        if (lock) begin
            grant     = lock_ch;
            grant_vld = in_valid[lock_ch];
        end else
`endif
        if (select_en) begin
            // Out-of-range indices simply never grant.
            if (int'(select) < NUM_IN) begin
                grant     = select;
                grant_vld = in_valid[select];
            end
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NUM_IN) begin
                    idx = idx - NUM_IN;
                end
                if (!grant_vld && in_valid[idx]) begin
                    grant     = SEL_W'(idx);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    // One-hot ready back to the granted producer only; silent during reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (accept && (grant == SEL_W'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    // Data path mux: word of the granted channel.
    always_comb begin
        grant_word = in_data[int'(grant)*WIDTH +: WIDTH];
    end

    // Pointer advance decision and wrapped successor of the grant.
    always_comb begin
        ptr_next = (grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + 1'b1;
`ifdef MUX_ARB_NBIT_LAST_LOCK_EN
        ptr_adv  = accept && in_last[grant] && (lock ? lock_rr : !select_en);
`else
        ptr_adv  = accept && !select_en;
`endif
    end

    // Output register: load on accept, empty on drain without accept, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            out        <= '0;
            out_valid  <= 1'b0;
            out_select <= '0;
        end else if (accept) begin
            out        <= grant_word;
            out_select <= grant;
            out_valid  <= 1'b1;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Round-robin pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (ptr_adv) begin
            ptr <= ptr_next;
        end
    end

`ifdef MUX_ARB_NBIT_LAST_LOCK_EN
    // Packet lock tracking: set on a non-last accept, cleared by the last word.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock    <= 1'b0;
            lock_ch <= '0;
            lock_rr <= 1'b0;
        end else if (accept) begin
            if (in_last[grant]) begin
                lock <= 1'b0;
            end else begin
                lock    <= 1'b1;
                lock_ch <= grant;
                lock_rr <= lock ? lock_rr : !select_en;
            end
        end
    end
`endif

    // Structural sanity: at most one producer is ever told ready.
    a_ready_onehot: assert property (@(posedge clk) $onehot0(in_ready));

    // A stalled output word must not change or vanish.
    a_stall_hold: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> (out_valid && $stable(out) && $stable(out_select)));

endmodule

// File: tb/tb_mux_arb_nbit.sv
// Bench for mux_arb_nbit (default parameters, 4 x 16-bit).
// The driver issues one cycle of stimulus at a time, predicts the grant from
// the arbitration rules and pushes the word expected on 'out' into exp_q.
// The monitor pops exp_q whenever the DUT completes an output transfer.

module tb_mux_arb_nbit;
    localparam int WIDTH  = 16;
    localparam int NUM_IN = 4;
    localparam int SEL_W  = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic                    select_en;
    logic [SEL_W-1:0]        select;
    logic [WIDTH-1:0]        out;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_W-1:0]        out_select;
`ifdef MUX_ARB_NBIT_LAST_LOCK_EN
    logic [NUM_IN-1:0]       in_last = '1;
`endif

    mux_arb_nbit #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
`ifdef MUX_ARB_NBIT_LAST_LOCK_EN
        .in_last    (in_last),
`endif
        .select_en  (select_en),
        .select     (select),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_select (out_select)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard state: {out_select, out} words expected, in order.
    logic [SEL_W+WIDTH-1:0] exp_q[$];
    int checks = 0;
    int passed = 0;
    bit started = 1'b0;

    // Reference model state (behavioural, not cycle-structured like the RTL).
    int m_ptr  = 0;
    bit m_full = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle, check in_ready against the model, push expected output.
    task automatic step(input bit rst, input logic [NUM_IN-1:0] v, input bit se,
                        input logic [SEL_W-1:0] sel, input bit ordy,
                        input logic [NUM_IN*WIDTH-1:0] d);
        int g;
        bit ld;
        logic [NUM_IN-1:0] exp_rdy;
        @(negedge clk);
        reset     = rst;
        in_valid  = v;
        select_en = se;
        select    = sel;
        out_ready = ordy;
        in_data   = d;
        #2;
        g = -1;
        if (se) begin
            if (int'(sel) < NUM_IN && v[sel]) g = int'(sel);
        end else begin
            for (int k = 0; k < NUM_IN; k++)
                if (g < 0 && v[(m_ptr + k) % NUM_IN]) g = (m_ptr + k) % NUM_IN;
        end
        ld = !m_full || ordy;
        exp_rdy = '0;
        if (g >= 0 && ld && !rst) exp_rdy[g] = 1'b1;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (rst) begin
            exp_q.delete();
            m_full = 1'b0;
            m_ptr  = 0;
        end else if (g >= 0 && ld) begin
            exp_q.push_back({SEL_W'(g), d[g*WIDTH +: WIDTH]});
            m_full = 1'b1;
            if (!se) m_ptr = (g + 1) % NUM_IN;
        end else if (ordy) begin
            m_full = 1'b0;
        end
    endtask

    // Monitor: compare the presented word, pop it when it is taken.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (started) begin
                check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
                if (out_valid && exp_q.size() != 0) begin
                    check("out_word", 64'({out_select, out}), 64'(exp_q[0]));
                    if (out_ready && !reset) void'(exp_q.pop_front());
                end
            end
        end
    end

    function automatic logic [NUM_IN*WIDTH-1:0] seq_data();
        logic [NUM_IN*WIDTH-1:0] d;
        for (int i = 0; i < NUM_IN; i++) d[i*WIDTH +: WIDTH] = WIDTH'(16'h00A0 + i);
        return d;
    endfunction

    function automatic logic [NUM_IN*WIDTH-1:0] rand_data();
        logic [NUM_IN*WIDTH-1:0] d;
        for (int i = 0; i < NUM_IN; i++) d[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        return d;
    endfunction

    initial begin
        logic [NUM_IN*WIDTH-1:0] d;
        reset = 1'b1; in_valid = '0; select_en = 1'b0; select = '0;
        out_ready = 1'b0; in_data = '0;

        // Reset held two cycles with every input requesting.
        d = seq_data();
        step(1, 4'b1111, 0, 0, 1, d);
        step(1, 4'b1111, 0, 0, 1, d);
        check("reset_out", 64'(out), 64'h0);
        check("reset_out_select", 64'(out_select), 64'h0);
        started = 1'b1;

        // Round-robin with all channels valid: A0, A1, A2, A3, A0.
        for (int n = 0; n < 5; n++) step(0, 4'b1111, 0, 0, 1, d);

        // Forced channel 2, then forced channel 0 with no word there.
        d[2*WIDTH +: WIDTH] = 16'hBEEF;
        step(0, 4'b0110, 1, 2, 1, d);
        step(0, 4'b0110, 1, 0, 1, d);
        step(0, 4'b0110, 1, 0, 1, d);

        // Backpressure while holding 1234, then release with no bubble.
        d[3*WIDTH +: WIDTH] = 16'h1234;
        step(0, 4'b1000, 1, 3, 1, d);
        for (int n = 0; n < 3; n++) step(0, 4'b1111, 0, 0, 0, d);
        step(0, 4'b1111, 0, 0, 1, d);
        step(0, 4'b1111, 0, 0, 1, d);

        // Reset in the middle of a stream, then restart from channel 0.
        step(1, 4'b1111, 0, 0, 1, d);
        step(0, 4'b1111, 0, 0, 1, d);
        step(0, 4'b1111, 0, 0, 1, d);

        // Randomised traffic, modes, backpressure and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 60) == 0),
                 NUM_IN'($urandom),
                 ($urandom_range(0, 3) == 0),
                 SEL_W'($urandom),
                 ($urandom_range(0, 3) != 0),
                 rand_data());
        end

        // Let the last word drain.
        step(0, 4'b0000, 0, 0, 1, d);
        step(0, 4'b0000, 0, 0, 1, d);
        @(negedge clk);
        #3;
        check("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
